// File: rtl/ex_bypass_net.sv
// ex_bypass_net: execute-stage operand bypass network with a DEPTH-entry writer history.
// Latency: the lookup and operand muxes are combinational. History shift, load fill and
// ld_lost update on the rising clk edge.
// Backpressure: stall is raised when a source hits a load that is still waiting for its data.
//   Ports: rs1/rs2 addr and rf data in; pc/imm with asel/bsel in; the EX writer
//   (ex_valid/ex_we/ex_is_load/ex_rd/ex_result) in; load return (ld_valid/ld_data) in.
//   rs1_br/rs2_br, alu_a/alu_b, stall and sticky ld_lost out.
// Optional: define EX_BYPASS_STATS_EN to add the fwd_hits and stall_cycles counters.
module ex_bypass_net #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_rf,
  input  logic [XLEN-1:0] rs2_rf,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            asel,
  input  logic            bsel,
  input  logic            ex_valid,
  input  logic            ex_we,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] rs1_br,
  output logic [XLEN-1:0] rs2_br,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            stall,
  output logic            ld_lost
`ifdef EX_BYPASS_STATS_EN
  ,
  output logic [31:0]     fwd_hits,
  output logic [31:0]     stall_cycles
`endif
);

  // History: index 0 is the youngest entry.
  logic [DEPTH-1:0] vld_q, vld_d, rdy_q, rdy_d;
  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       rd_d  [DEPTH];
  logic [XLEN-1:0]  dat_q [DEPTH];
  logic [XLEN-1:0]  dat_d [DEPTH];
  logic             ld_lost_q, ld_lost_d;

  logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
  logic             rs1_haz, rs2_haz;
`ifdef EX_BYPASS_STATS_EN
  logic             rs1_hit, rs2_hit;
`endif

  // Lookup: walk from oldest to youngest so the youngest match is the last
  // one written and therefore wins.
  always_comb begin
    rs1_fwd = rs1_rf;
    rs2_fwd = rs2_rf;
    rs1_haz = 1'b0;
    rs2_haz = 1'b0;
`ifdef EX_BYPASS_STATS_EN
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
`endif
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && (rd_q[i] == rs1_addr) && (rs1_addr != 5'd0)) begin
        rs1_haz = !rdy_q[i];
        rs1_fwd = rdy_q[i] ? dat_q[i] : rs1_rf;
`ifdef EX_BYPASS_STATS_EN
        rs1_hit = rdy_q[i];
`endif
      end
      if (vld_q[i] && (rd_q[i] == rs2_addr) && (rs2_addr != 5'd0)) begin
        rs2_haz = !rdy_q[i];
        rs2_fwd = rdy_q[i] ? dat_q[i] : rs2_rf;
`ifdef EX_BYPASS_STATS_EN
        rs2_hit = rdy_q[i];
`endif
      end
    end
  end

  assign rs1_br  = rs1_fwd;
  assign rs2_br  = rs2_fwd;
  assign alu_a   = asel ? pc  : rs1_fwd;
  assign alu_b   = bsel ? imm : rs2_fwd;
  assign stall   = rs1_haz | rs2_haz;
  assign ld_lost = ld_lost_q;

  // Next state: shift by one, insert the EX writer at slot 0, then let a load
  // return fill the oldest pending entry among the post-shift slots 1..DEPTH-1.
  // Slot 0 is excluded because the instruction entering this cycle cannot
  // already have its load data.
  logic [DEPTH-1:0] fill_oh;
  logic             fill_found;

  always_comb begin
    fill_oh    = '0;
    fill_found = 1'b0;
    for (int i = DEPTH - 1; i >= 1; i--) begin
      if (!fill_found && vld_q[i-1] && !rdy_q[i-1]) begin
        fill_found = 1'b1;
        fill_oh[i] = 1'b1;
      end
    end

    vld_d    = '0;
    rdy_d    = '0;
    vld_d[0] = ex_valid & ex_we & (ex_rd != 5'd0);
    rdy_d[0] = !ex_is_load;
    rd_d[0]  = ex_rd;
    dat_d[0] = ex_result;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      rd_d[i]  = rd_q[i-1];
      if (ld_valid && fill_oh[i]) begin
        rdy_d[i] = 1'b1;
        dat_d[i] = ld_data;
      end else begin
        rdy_d[i] = rdy_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    // The oldest slot falls off this edge; losing a pending load is sticky.
    ld_lost_d = ld_lost_q | (vld_q[DEPTH-1] & !rdy_q[DEPTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      rdy_q     <= '0;
      ld_lost_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      rdy_q     <= rdy_d;
      ld_lost_q <= ld_lost_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= rd_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

`ifdef EX_BYPASS_STATS_EN
  logic [31:0] fwd_hits_q, stall_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hits_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      fwd_hits_q     <= fwd_hits_q + 32'(rs1_hit | rs2_hit);
      stall_cycles_q <= stall_cycles_q + 32'(stall);
    end
  end

  assign fwd_hits     = fwd_hits_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule
